// File: rtl/fb_pkg.sv
// fb_pkg: opcodes, memory-map constants and the command type shared by the palette/framebuffer writer and reader.
// No ports; imported with import fb_pkg::*.
package fb_pkg;
    typedef enum logic [1:0] {
        OP_PIXEL   = 2'b00,
        OP_PALETTE = 2'b01,
        OP_FILL    = 2'b10,
        OP_RSVD    = 2'b11
    } fb_op_e;

    localparam int BYTES_PER_COLOR    = 2;
    localparam int COLORS_PER_PALETTE = 256;
    localparam int COLOR_BASE_ADDR    = 0;
    localparam int FB_BASE_ADDR       = 512;
    // Wide enough for any supported FB_BITS; narrower indices are zero-extended.
    localparam int CMD_INDEX_BITS     = 32;

    typedef struct packed {
        fb_op_e                    op;
        logic [CMD_INDEX_BITS-1:0] index;
        logic [15:0]               data;
    } fb_cmd_t;
endpackage

// File: rtl/fb_cmd_fifo.sv
// fb_cmd_fifo: synchronous command FIFO with registered full/empty flags.
// Ports: clk_i, reset_i (async, active-high); push_i/din_i write side; pop_i/dout_o read side (dout_o shows the head);
// full_o, empty_o status.
module fb_cmd_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk_i,
    input  logic    reset_i,
    input  logic    push_i,
    input  fb_cmd_t din_i,
    input  logic    pop_i,
    output fb_cmd_t dout_o,
    output logic    full_o,
    output logic    empty_o
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fb_cmd_fifo: DEPTH must be a power of two >= 2");
    end

    fb_cmd_t       mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_q];
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;

    always_comb begin
        wr_d  = do_push ? wr_q + AW'(1) : wr_q;
        rd_d  = do_pop ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end
endmodule

// File: rtl/fb_writer.sv
// fb_writer: turns host pixel / palette / fill commands into byte-lane writes on the shared BRAM write port.
// Ports: clk_i, reset_i (async, active-high); cmd_valid_i/cmd_ready_o handshake with cmd_op_i, cmd_index_i, cmd_data_i;
// busy_o, fill_done_o status; bram_clk_o, bram_rst_o, bram_en_o, bram_addr_o, bram_din_o, bram_we_o registered write port.
// Memory map: palette entry e at byte 2e, pixel p at byte 512+p.
// Optional: define FB_WRITER_ABORT_EN to add abort_i, which ends a fill early.
module fb_writer
    import fb_pkg::*;
#(
    parameter int FB_BITS        = 17,
    parameter int FB_PIXELS      = 76800,
    parameter int BRAM_ADDR_BITS = 32,
    parameter int BRAM_DATA_BITS = 32,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
`ifdef FB_WRITER_ABORT_EN
    input  logic                        abort_i,
`endif
    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic [1:0]                  cmd_op_i,
    input  logic [FB_BITS-1:0]          cmd_index_i,
    input  logic [15:0]                 cmd_data_i,
    output logic                        busy_o,
    output logic                        fill_done_o,
    output logic                        bram_clk_o,
    output logic                        bram_rst_o,
    output logic                        bram_en_o,
    output logic [BRAM_ADDR_BITS-1:0]   bram_addr_o,
    output logic [BRAM_DATA_BITS-1:0]   bram_din_o,
    output logic [BRAM_DATA_BITS/8-1:0] bram_we_o
);
    localparam int WE_BITS    = BRAM_DATA_BITS / 8;
    localparam int FILL_WORDS = (FB_PIXELS + 3) / 4;
    localparam int FILL_REM   = FB_PIXELS % 4;
    // The final fill word only enables the lanes that hold real pixels.
    localparam logic [3:0] LAST_WE = (FILL_REM == 0) ? 4'b1111 : 4'((1 << FILL_REM) - 1);

    if (BRAM_DATA_BITS != 32) begin : g_bad_data
        $error("fb_writer: only BRAM_DATA_BITS = 32 is supported");
    end
    if (FB_BITS > CMD_INDEX_BITS || FB_PIXELS < 1 ||
        longint'(FB_PIXELS) > (longint'(1) << FB_BITS)) begin : g_bad_pixels
        $error("fb_writer: FB_PIXELS must fit in FB_BITS");
    end

    typedef enum logic {S_IDLE, S_FILL} state_e;

    state_e                    state_q, state_d;
    fb_cmd_t                   in_cmd, head, cmd_q, cmd_d;
    logic                      cmd_vld_q, cmd_vld_d;
    logic [FB_BITS-1:0]        w_q, w_d;
    logic                      pend_q, pend_d, done_q, done_d;
    logic                      en_q, en_d;
    logic [BRAM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [31:0]               din_q, din_d;
    logic [3:0]                we_q, we_d;
    logic                      push, pop, full, empty, abort, last;
    logic [31:0]               pix_a, pal_a;

`ifdef FB_WRITER_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    assign in_cmd = '{op: fb_op_e'(cmd_op_i), index: CMD_INDEX_BITS'(cmd_index_i), data: cmd_data_i};
    assign push   = cmd_valid_i && !full;

    fb_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (push),
        .din_i   (in_cmd),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign pix_a = 32'(FB_BASE_ADDR) + cmd_q.index;
    assign pal_a = 32'(COLOR_BASE_ADDR) + 32'(BYTES_PER_COLOR) * 32'(cmd_q.index[7:0]);
    assign last  = w_q == FB_BITS'(FILL_WORDS - 1);

    // cmd_q is a decode slot between the FIFO head and the write registers; it holds the fill command
    // (and its color) for the whole fill.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        en_d    = 1'b0;
        addr_d  = '0;
        din_d   = '0;
        we_d    = '0;
        pend_d  = 1'b0;
        done_d  = pend_q;
        pop     = 1'b0;
        if (state_q == S_IDLE) begin
            // A fill waiting in the decode slot blocks further pops so nothing is consumed ahead of it.
            pop = !empty && !(cmd_vld_q && cmd_q.op == OP_FILL);
            if (cmd_vld_q) begin
                case (cmd_q.op)
                    OP_PIXEL: if (cmd_q.index < CMD_INDEX_BITS'(FB_PIXELS)) begin
                        en_d   = 1'b1;
                        addr_d = BRAM_ADDR_BITS'({pix_a[31:2], 2'b00});
                        we_d   = 4'b0001 << pix_a[1:0];
                        din_d  = {4{cmd_q.data[7:0]}};
                    end
                    OP_PALETTE: begin
                        en_d   = 1'b1;
                        addr_d = BRAM_ADDR_BITS'({pal_a[31:2], 2'b00});
                        we_d   = pal_a[1] ? 4'b1100 : 4'b0011;
                        din_d  = {2{cmd_q.data}};
                    end
                    OP_FILL: begin
                        state_d = S_FILL;
                        w_d     = '0;
                    end
                    default: ;
                endcase
            end
        end else if (abort) begin
            state_d = S_IDLE;
            pend_d  = 1'b1;
        end else begin
            en_d   = 1'b1;
            addr_d = BRAM_ADDR_BITS'(FB_BASE_ADDR) + BRAM_ADDR_BITS'({w_q, 2'b00});
            we_d   = last ? LAST_WE : 4'b1111;
            din_d  = {4{cmd_q.data[7:0]}};
            w_d    = w_q + FB_BITS'(1);
            if (last) begin
                state_d = S_IDLE;
                pend_d  = 1'b1;
            end
        end
        cmd_vld_d = pop;
        cmd_d     = pop ? head : cmd_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            cmd_q     <= '0;
            cmd_vld_q <= 1'b0;
            w_q       <= '0;
            pend_q    <= 1'b0;
            done_q    <= 1'b0;
            en_q      <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            we_q      <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            cmd_vld_q <= cmd_vld_d;
            w_q       <= w_d;
            pend_q    <= pend_d;
            done_q    <= done_d;
            en_q      <= en_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            we_q      <= we_d;
        end
    end

    assign cmd_ready_o = !full;
    assign busy_o      = !empty || cmd_vld_q || state_q == S_FILL;
    assign fill_done_o = done_q;
    assign bram_clk_o  = clk_i;
    assign bram_rst_o  = reset_i;
    assign bram_en_o   = en_q;
    assign bram_addr_o = addr_q;
    assign bram_din_o  = BRAM_DATA_BITS'(din_q);
    assign bram_we_o   = WE_BITS'(we_q);
endmodule

// File: tb/tb_fb_writer.sv
// tb_fb_writer: directed and randomized bench for fb_writer, checked against a list of expected BRAM writes
// derived from the memory map (FB_PIXELS = 10 so fills are short and end on a partial word).
module tb_fb_writer;
    localparam int NPIX = 10;
    localparam int FBB  = 17;

    logic            clk_i = 1'b0, reset_i = 1'b1, cmd_valid_i = 1'b0;
    logic [1:0]      cmd_op_i = '0;
    logic [FBB-1:0]  cmd_index_i = '0;
    logic [15:0]     cmd_data_i = '0;
    logic            cmd_ready_o, busy_o, fill_done_o, bram_clk_o, bram_rst_o, bram_en_o;
    logic [31:0]     bram_addr_o, bram_din_o;
    logic [3:0]      bram_we_o;
`ifdef FB_WRITER_ABORT_EN
    logic            abort_i = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] din;
        bit          last;
    } wr_t;

    wr_t exp_q[$];
    int  wr_cyc[$];
    int  tests = 0, fails = 0, cyc = 0, done_due = -1, fill_last_cyc = -1;

    always #5 clk_i = ~clk_i;

    fb_writer #(.FB_BITS(FBB), .FB_PIXELS(NPIX)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
`ifdef FB_WRITER_ABORT_EN
        .abort_i     (abort_i),
`endif
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_op_i    (cmd_op_i),
        .cmd_index_i (cmd_index_i),
        .cmd_data_i  (cmd_data_i),
        .busy_o      (busy_o),
        .fill_done_o (fill_done_o),
        .bram_clk_o  (bram_clk_o),
        .bram_rst_o  (bram_rst_o),
        .bram_en_o   (bram_en_o),
        .bram_addr_o (bram_addr_o),
        .bram_din_o  (bram_din_o),
        .bram_we_o   (bram_we_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected writes from the memory map: pixel p at byte 512+p, palette entry e at bytes 2e..2e+1,
    // fill covers bytes 512..512+NPIX-1 one word at a time.
    task automatic model(input logic [1:0] op, input int idx, input logic [15:0] d);
        int a;
        logic [3:0] m;
        case (op)
            2'b00: if (idx < NPIX) begin
                a = 512 + idx;
                exp_q.push_back('{32'(a - a % 4), 4'(1 << (a % 4)), {4{d[7:0]}}, 1'b0});
            end
            2'b01: begin
                a = 2 * (idx % 256);
                exp_q.push_back('{32'(a - a % 4), (a % 4 == 2) ? 4'b1100 : 4'b0011, {d, d}, 1'b0});
            end
            2'b10: for (int w = 0; w < (NPIX + 3) / 4; w++) begin
                m = '0;
                for (int b = 0; b < 4; b++) m[b] = (4 * w + b < NPIX);
                exp_q.push_back('{32'(512 + 4 * w), m, {4{d[7:0]}}, (4 * w + 4 >= NPIX)});
            end
            default: ;
        endcase
    endtask

    task automatic tick();
        wr_t e;
        @(posedge clk_i);
        #1;
        cyc++;
        if (bram_en_o) begin
            wr_cyc.push_back(cyc);
            chk("write_expected", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", bram_addr_o, e.addr);
                chk("wr_we", bram_we_o, e.we);
                chk("wr_din", bram_din_o, e.din);
                if (e.last) begin
                    done_due      = cyc + 1;
                    fill_last_cyc = cyc;
                end
            end
        end
        if (cyc == done_due) chk("fill_done", fill_done_o, 1);
        else if (fill_done_o) chk("fill_done_spurious", fill_done_o, 0);
    endtask

    task automatic send(input logic [1:0] op, input int idx, input logic [15:0] d);
        int n = 0;
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_index_i = FBB'(idx);
        cmd_data_i  = d;
        while (!cmd_ready_o && n < 50) begin
            tick();
            n++;
        end
        if (!cmd_ready_o) chk("ready_timeout", cmd_ready_o, 1);
        else begin
            tick();
            model(op, idx, d);
        end
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_en();
        int n = 0;
        while (!bram_en_o && n < 20) begin
            tick();
            n++;
        end
        chk("wait_en", bram_en_o, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((busy_o || exp_q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        repeat (3) tick();
        chk("drain_busy", busy_o, 0);
        chk("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        int bp_start, r;
        tick();
        tick();
        chk("rst_en", bram_en_o, 0);
        chk("rst_we", bram_we_o, 0);
        chk("rst_addr", bram_addr_o, 0);
        chk("rst_din", bram_din_o, 0);
        chk("rst_done", fill_done_o, 0);
        chk("rst_busy", busy_o, 0);
        reset_i = 1'b0;
        tick();
        chk("rst_ready", cmd_ready_o, 1);

        send(2'b00, 5, 16'h00AB);
        tick();
        chk("pix_lat_early", bram_en_o, 0);
        tick();
        chk("pix_en", bram_en_o, 1);
        chk("pix_addr", bram_addr_o, 32'h204);
        chk("pix_we", bram_we_o, 4'b0010);
        chk("pix_din", bram_din_o, 32'hABABABAB);
        tick();
        chk("pix_single", bram_en_o, 0);

        send(2'b01, 3, 16'h0F0A);
        tick();
        tick();
        chk("pal_en", bram_en_o, 1);
        chk("pal_addr", bram_addr_o, 32'h4);
        chk("pal_we", bram_we_o, 4'b1100);
        chk("pal_din", bram_din_o, 32'h0F0A0F0A);
        drain();

        send(2'b10, 0, 16'h0011);
        wait_en();
        chk("fill0_addr", bram_addr_o, 32'h200);
        chk("fill0_we", bram_we_o, 4'b1111);
        chk("fill0_din", bram_din_o, 32'h11111111);
        tick();
        chk("fill1_addr", bram_addr_o, 32'h204);
        chk("fill1_we", bram_we_o, 4'b1111);
        tick();
        chk("fill2_addr", bram_addr_o, 32'h208);
        chk("fill2_we", bram_we_o, 4'b0011);
        chk("fill2_din", bram_din_o, 32'h11111111);
        tick();
        chk("fill_done_pulse", fill_done_o, 1);
        chk("fill_done_no_write", bram_en_o, 0);
        tick();
        chk("fill_done_once", fill_done_o, 0);
        drain();

        wr_cyc.delete();
        send(2'b10, 0, 16'h0022);
        bp_start = cyc;
        for (int i = 0; i < 4; i++) send(2'b00, i, 16'(8'h30 + i));
        chk("bp_four_fast", cyc - bp_start, 4);
        chk("bp_ready_low", cmd_ready_o, 0);
        chk("bp_busy", busy_o, 1);
        send(2'b00, 4, 16'h0034);
        chk("bp_fill_ended", 64'(fill_last_cyc > bp_start), 1);
        chk("bp_accept_after_fill", 64'(cyc > fill_last_cyc), 1);
        drain();
        chk("bp_writes", wr_cyc.size(), 8);
        if (wr_cyc.size() >= 8)
            for (int i = 1; i < 4; i++) chk("bp_consecutive", wr_cyc[3 + i] - wr_cyc[3], i);

        wr_cyc.delete();
        send(2'b11, 7, 16'h00FF);
        send(2'b00, 76800, 16'h0055);
        send(2'b00, NPIX, 16'h0056);
        send(2'b00, NPIX - 1, 16'h0057);
        drain();
        chk("drop_writes", wr_cyc.size(), 1);

        send(2'b10, 0, 16'h0077);
        wait_en();
        #2 reset_i = 1'b1;
        #1;
        chk("midrst_en", bram_en_o, 0);
        chk("midrst_we", bram_we_o, 0);
        chk("midrst_addr", bram_addr_o, 0);
        chk("midrst_din", bram_din_o, 0);
        exp_q.delete();
        done_due = -1;
        tick();
        tick();
        reset_i = 1'b0;
        tick();
        chk("midrst_ready", cmd_ready_o, 1);
        chk("midrst_busy", busy_o, 0);
        repeat (5) tick();

        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            repeat ($urandom_range(0, 2)) tick();
            if (r == 0) send(2'b10, 0, 16'($urandom));
            else if (r == 1) send(2'b11, $urandom_range(0, 255), 16'($urandom));
            else if (r < 6) send(2'b01, $urandom_range(0, 131071), 16'($urandom));
            else send(2'b00, $urandom_range(0, NPIX + 2), 16'($urandom));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fb_writer.md
Name: fb_writer

Overview:
- Write-side counterpart of the palette/framebuffer reader. Accepts host commands and turns them into BRAM byte-lane writes into the shared palette + framebuffer memory.
- Commands are: write one framebuffer pixel index, write one palette entry, or fill the entire framebuffer with one color index.
- Sits between the command source (CPU bridge / rasterizer) and the write port of the dual-port BRAM whose other port feeds the display pipeline.

Parameters:
- FB_BITS, 17, width of pixel index.
- FB_PIXELS, 76800, number of framebuffer pixels (one byte each); must be ≤ 2**FB_BITS.
- BRAM_ADDR_BITS, 32, BRAM byte-address width.
- BRAM_DATA_BITS, 32, BRAM word width; only 32 supported (elaboration error otherwise).
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥ 2.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command FIFO not full.
- cmd_op_i  in  2  opcode: 00 pixel, 01 palette, 10 fill, 11 reserved.
- cmd_index_i  in  FB_BITS  pixel index (op 00) or palette entry in [7:0] (op 01); ignored for fill.
- cmd_data_i  in  16  color index in [7:0] (ops 00/10) or ARGB4444 (op 01).
- busy_o  out  1  FIFO non-empty or fill in progress.
- fill_done_o  out  1  one-cycle pulse after the last fill write.
- bram_clk_o  out  1  equals clk_i.
- bram_rst_o  out  1  equals reset_i.
- bram_en_o  out  1  high only on write cycles.
- bram_addr_o  out  BRAM_ADDR_BITS  word-aligned byte address (bits [1:0] = 0).
- bram_din_o  out  BRAM_DATA_BITS  write data.
- bram_we_o  out  BRAM_DATA_BITS/8  byte write enables.

Behaviour:
- Memory map:
  - Palette at byte 0: 256 entries × 2 bytes, entry e at byte 2e.
  - Framebuffer at byte 512, pixel p at byte 512+p.
- Reset: FIFO emptied, FSM to IDLE. bram_en_o, bram_we_o, bram_addr_o, bram_din_o, fill_done_o and busy_o are all 0; cmd_ready_o is 1 after reset deasserts.
- Handshake: command accepted on an edge where cmd_valid_i && cmd_ready_o. cmd_ready_o = !fifo_full, registered, with no combinational dependence on pop. Push and pop in the same cycle are allowed; occupancy is unchanged.
- FSM states and transitions:
  - IDLE: if FIFO non-empty, pop head. Op 00/01 issues a write and stays in IDLE, giving back-to-back one write per cycle. Op 10 goes to FILL. Op 11 is dropped with no BRAM activity.
  - FILL: word counter w runs 0..W-1, W = ceil(FB_PIXELS/4). Each cycle writes addr 512+4w, din = {4{byte}}. we = 4'b1111, except the final word when FB_PIXELS%4 ≠ 0, where we = (1<<(FB_PIXELS%4))-1. After the last write: fill_done_o pulses the next cycle and the FSM returns to IDLE. No pops occur during FILL.
- Pixel write: a = 512+p, addr = a & ~3, we = 1<<a[1:0], din = {4{data[7:0]}}.
- Palette write: a = 2e, addr = a & ~3, we = a[1] ? 4'b1100 : 4'b0011, din = {2{data}}.
- All BRAM outputs are registered. Latency from accept to bram_we_o assertion is exactly 2 cycles when the FIFO was empty and the FSM was IDLE.
- Out of range: pixel index ≥ FB_PIXELS is dropped with no write.
- Reset mid-fill: outputs clear immediately, FIFO contents are lost, no fill_done_o pulse.

Optional Feature:
- FB_WRITER_ABORT_EN
  - Defined: adds input abort_i (1 bit). abort_i high during FILL issues no further writes after the current edge, returns to IDLE, and pulses fill_done_o the next cycle. abort_i outside FILL is ignored. Queued FIFO commands are retained.
  - Undefined: port absent; fill always runs to completion.

Decomposition:
- Package fb_pkg:
  - Opcode enum: OP_PIXEL, OP_PALETTE, OP_FILL, OP_RSVD.
  - Constants: BYTES_PER_COLOR=2, COLORS_PER_PALETTE=256, COLOR_BASE_ADDR=0, FB_BASE_ADDR=512.
  - Packed command struct {op, index, data}.
  - The palette reader adopts these same constants.
- Sub-module fb_cmd_fifo: synchronous FIFO of command structs with full/empty flags, async reset.

Test Plan:
- Pixel write p=5, data 0x00AB -> 2 cycles later: en=1, addr=0x204, we=4'b0010, din=0xABABABAB; single cycle.
- Palette write e=3, data 0x0F0A -> addr=0x4, we=4'b1100, din=0x0F0A0F0A.
- FB_PIXELS=10, fill 0x11 -> 3 consecutive writes:
  - addr 0x200 / 0x204 / 0x208.
  - we 1111 / 1111 / 0011.
  - din 0x11111111.
  - fill_done_o pulses once the following cycle.
- Backpressure: issue fill, then 5 pixel commands held valid -> 4 accepted, cmd_ready_o low until fill ends. The pixel writes then appear on consecutive cycles in order.
- Reserved op and pixel index 76800 -> consumed, no en/we activity; busy_o falls after drain.
- Assert reset_i mid-fill -> en/we/addr/din read 0 in the same cycle. No fill_done_o. After release, cmd_ready_o = 1 and busy_o = 0.
